// File: rtl/lfsr_pkg.sv
// lfsr_pkg: shared constants, state encoding and LFSR step helpers
// for the 26-bit Fibonacci LFSR and its two-requester arbiter.
// Bits are numbered [1:26] throughout; bit 1 receives the feedback.
package lfsr_pkg;

    localparam int unsigned LFSR_WIDTH = 26;

    // Feedback taps (positions in [1:26] numbering)
    localparam int unsigned TAP_A = 26;
    localparam int unsigned TAP_B = 6;
    localparam int unsigned TAP_C = 2;
    localparam int unsigned TAP_D = 1;

    localparam logic [1:LFSR_WIDTH] LFSR_DEFAULT_SEED = 26'b1101_1001_0101_1010_1101_0110_01;

    typedef enum logic [1:0] {
        WARM,
        READY,
        STEP,
        DELIVER
    } state_t;

    function automatic logic feedback(input logic [1:LFSR_WIDTH] q);
        return q[TAP_A] ^ q[TAP_B] ^ q[TAP_C] ^ q[TAP_D];
    endfunction

    // One shift: new bit 1 is the feedback, every other bit moves up one place
    function automatic logic [1:LFSR_WIDTH] lfsr_advance(input logic [1:LFSR_WIDTH] q);
        return {feedback(q), q[1:LFSR_WIDTH-1]};
    endfunction

endpackage

// File: rtl/lfsr26_core.sv
// lfsr26_core: bare 26-bit Fibonacci shift register. Reset and load
// set the state directly; otherwise it advances once per cycle with step.
module lfsr26_core
    import lfsr_pkg::*;
#(
    parameter logic [1:LFSR_WIDTH] SEED = LFSR_DEFAULT_SEED
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [1:LFSR_WIDTH]   din,
    input  logic                  step,
    output logic [1:LFSR_WIDTH]   q
);

    // State register: reset > load > step > hold
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= SEED;
        end else if (load) begin
            q <= din;
        end else if (step) begin
            q <= lfsr_advance(q);
        end
    end

endmodule

// File: rtl/lfsr_arbiter.sv
// lfsr_arbiter: shares one 26-bit LFSR between two req/ack requesters.
// Handles seeding, warm-up, round-robin grant and decorrelation steps.
// Optional: define LFSR_ARB_ZERO_GUARD_EN to replace an all-zero seed
// with DEFAULT_SEED at load time.
module lfsr_arbiter
    import lfsr_pkg::*;
#(
    parameter int unsigned         W            = 8,
    parameter int unsigned         STEPS        = 8,
    parameter int unsigned         WARMUP       = 26,
    parameter logic [1:LFSR_WIDTH] DEFAULT_SEED = LFSR_DEFAULT_SEED
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  seed_load,
    input  logic [1:LFSR_WIDTH]   seed_din,
    input  logic                  req0,
    input  logic                  req1,
    output logic                  ack0,
    output logic                  ack1,
    output logic [1:W]            rdata,
    output logic                  busy,
    output logic [1:LFSR_WIDTH]   lfsr_q
);

    localparam state_t START_STATE = (WARMUP == 0) ? READY : WARM;

    state_t       state, state_n;
    logic [31:0]  cnt, cnt_n;
    logic         gnt, gnt_n;       // 0 = requester 0, 1 = requester 1
    logic         ptr, ptr_n;       // last requester actually served
    logic         ack0_n, ack1_n;
    logic [1:W]   rdata_n;
    logic         busy_n;
    logic         lfsr_step;
    logic [1:LFSR_WIDTH] load_val;
    logic         fb;
    logic [1:W]   word_next;

`ifdef LFSR_ARB_ZERO_GUARD_EN
    assign load_val = (seed_din == '0) ? DEFAULT_SEED : seed_din;
`else
    assign load_val = seed_din;
`endif

    lfsr26_core #(
        .SEED (DEFAULT_SEED)
    ) u_core (
        .clk  (clk),
        .rst  (rst),
        .load (seed_load),
        .din  (load_val),
        .step (lfsr_step),
        .q    (lfsr_q)
    );

    // Word the LFSR will hold after its next advance, so rdata is valid
    // in the same cycle as ack rather than one cycle later.
    assign fb = feedback(lfsr_q);

    generate
        if (W == 1) begin : g_word_w1
            assign word_next = fb;
        end else begin : g_word_wn
            assign word_next = {fb, lfsr_q[1:W-1]};
        end
    endgenerate

    // Next-state, counter, grant and output decode; seed_load overrides all
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        gnt_n     = gnt;
        ptr_n     = ptr;
        ack0_n    = 1'b0;
        ack1_n    = 1'b0;
        rdata_n   = rdata;
        lfsr_step = 1'b0;

        if (seed_load) begin
            state_n = START_STATE;
            cnt_n   = WARMUP;
        end else begin
            case (state)
                WARM: begin
                    lfsr_step = 1'b1;
                    if (cnt <= 32'd1) begin
                        state_n = READY;
                    end else begin
                        cnt_n = cnt - 32'd1;
                    end
                end
                READY: begin
                    if (req0 || req1) begin
                        gnt_n   = (req0 && req1) ? ~ptr : req1;
                        cnt_n   = STEPS;
                        state_n = STEP;
                    end
                end
                STEP: begin
                    lfsr_step = 1'b1;
                    if (cnt <= 32'd1) begin
                        state_n = DELIVER;
                        ack0_n  = ~gnt;
                        ack1_n  = gnt;
                        ptr_n   = gnt;
                        rdata_n = word_next;
                    end else begin
                        cnt_n = cnt - 32'd1;
                    end
                end
                DELIVER: begin
                    state_n = READY;
                end
                default: begin
                    state_n = START_STATE;
                end
            endcase
        end

        busy_n = (state_n != READY);
    end

    // Registered state, counters, pointer and all outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= START_STATE;
            cnt   <= WARMUP;
            gnt   <= 1'b0;
            ptr   <= 1'b1;
            ack0  <= 1'b0;
            ack1  <= 1'b0;
            rdata <= '0;
            busy  <= (WARMUP != 0);
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            gnt   <= gnt_n;
            ptr   <= ptr_n;
            ack0  <= ack0_n;
            ack1  <= ack1_n;
            rdata <= rdata_n;
            busy  <= busy_n;
        end
    end

endmodule

// File: tb/tb_lfsr_arbiter.sv
// tb_lfsr_arbiter: directed self-checking bench for lfsr_arbiter
// (W=8, STEPS=8, WARMUP=26) with an independent LFSR reference model
// and a scoreboard of expected deliveries.
module tb_lfsr_arbiter;

    localparam logic [1:26] DSEED = 26'b1101_1001_0101_1010_1101_0110_01;
    localparam int WARM_N  = 26;
    localparam int STEP_N  = 8;

    logic        clk;
    logic        rst;
    logic        seed_load;
    logic [1:26] seed_din;
    logic        req0, req1;
    logic        ack0, ack1;
    logic [1:8]  rdata;
    logic        busy;
    logic [1:26] lfsr_q;

    typedef struct {
        logic [1:0] ackv;
        logic [7:0] data;
        int         cyc;
    } exp_t;

    exp_t        sbq[$];
    logic [1:26] m;          // model LFSR state
    logic        last;       // model round-robin pointer
    int          cyc;
    int          errors;
    int          checks;

    lfsr_arbiter #(
        .W            (8),
        .STEPS        (8),
        .WARMUP       (26),
        .DEFAULT_SEED (DSEED)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .seed_load (seed_load),
        .seed_din  (seed_din),
        .req0      (req0),
        .req1      (req1),
        .ack0      (ack0),
        .ack1      (ack1),
        .rdata     (rdata),
        .busy      (busy),
        .lfsr_q    (lfsr_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [1:26] madv(input logic [1:26] q);
        logic [1:26] r;
        r[1] = q[26] ^ q[6] ^ q[2] ^ q[1];
        for (int i = 2; i <= 26; i++) r[i] = q[i-1];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Expectation for a grant latched in the current READY cycle
    task automatic push_exp(input logic idx);
        exp_t e;
        for (int i = 0; i < STEP_N; i++) m = madv(m);
        e.ackv = idx ? 2'b10 : 2'b01;
        e.data = m[1:8];
        e.cyc  = cyc + STEP_N + 1;
        last   = idx;
        sbq.push_back(e);
    endtask

    function automatic logic tie_grant(input logic r0, input logic r1);
        return (r0 && r1) ? ~last : r1;
    endfunction

    task automatic wait_ack(input int bound, input bit hold);
        int   n;
        logic got;
        exp_t e;
        n   = 0;
        got = 1'b0;
        while (!got && n < bound) begin
            tick();
            n++;
            if (ack0 || ack1) got = 1'b1;
        end
        chk("ack_seen", {31'd0, got}, 32'd1);
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            if (got) begin
                chk("ack_vec", {30'd0, ack1, ack0}, {30'd0, e.ackv});
                chk("rdata", {24'd0, rdata}, {24'd0, e.data});
                chk("ack_cycle", cyc, e.cyc);
            end
        end
        if (!hold) begin
            req0 = 1'b0;
            req1 = 1'b0;
        end
    endtask

    // Count the warm-up cycles, then expect READY with the advanced model
    task automatic warm_wait();
        for (int i = 0; i < WARM_N; i++) begin
            chk("warm_busy", {31'd0, busy}, 32'd1);
            tick();
            m = madv(m);
        end
        chk("ready_busy", {31'd0, busy}, 32'd0);
        chk("warm_lfsr", {6'd0, lfsr_q}, {6'd0, m});
    endtask

    task automatic do_seed(input logic [1:26] s);
        seed_din  = s;
        seed_load = 1'b1;
        tick();
        seed_load = 1'b0;
        m = s;
`ifdef LFSR_ARB_ZERO_GUARD_EN
        if (s == '0) m = DSEED;
`endif
        chk("seed_lfsr", {6'd0, lfsr_q}, {6'd0, m});
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        cyc       = 0;
        rst       = 1'b1;
        seed_load = 1'b0;
        seed_din  = '0;
        req0      = 1'b0;
        req1      = 1'b0;
        m         = DSEED;
        last      = 1'b1;

        // Reset values
        tick();
        tick();
        chk("rst_lfsr", {6'd0, lfsr_q}, {6'd0, DSEED});
        chk("rst_ack", {30'd0, ack1, ack0}, 32'd0);
        chk("rst_rdata", {24'd0, rdata}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd1);
        rst = 1'b0;
        warm_wait();

        // Single request from requester 0
        req0 = 1'b1;
        push_exp(1'b0);
        wait_ack(30, 1'b0);
        tick();
        chk("ack_pulse", {30'd0, ack1, ack0}, 32'd0);
        chk("rdata_hold", {24'd0, rdata}, {24'd0, m[1:8]});

        // Both requesters held: alternating grants, 10-cycle spacing
        req0 = 1'b1;
        req1 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            push_exp(tie_grant(1'b1, 1'b1));
            wait_ack(30, (k < 3));
            tick();
        end

        // Same seed twice gives the same word sequence
        for (int r = 0; r < 2; r++) begin
            do_seed(26'h2A5C3F1);
            warm_wait();
            req0 = 1'b1;
            req1 = 1'b1;
            for (int k = 0; k < 3; k++) begin
                push_exp(tie_grant(1'b1, 1'b1));
                wait_ack(30, (k < 2));
                tick();
            end
        end

        // All-zero seed
        do_seed('0);
        warm_wait();
        req1 = 1'b1;
        push_exp(1'b1);
        wait_ack(30, 1'b0);
        tick();

        // Seed reload in the 4th STEP cycle of a req1 grant abandons it
        do_seed(26'h1B3D5E7);
        warm_wait();
        req1 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("abandon_noack", {30'd0, ack1, ack0}, 32'd0);
        end
        do_seed(26'h0F0F0F3);
        for (int i = 0; i < WARM_N; i++) begin
            tick();
            m = madv(m);
        end
        push_exp(1'b1);
        wait_ack(30, 1'b0);
        tick();

        // Reset during DELIVER drops the ack and restores reset values
        req0 = 1'b1;
        push_exp(1'b0);
        wait_ack(30, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstdel_ack0", {31'd0, ack0}, 32'd0);
        chk("rstdel_rdata", {24'd0, rdata}, 32'd0);
        chk("rstdel_lfsr", {6'd0, lfsr_q}, {6'd0, DSEED});
        chk("rstdel_busy", {31'd0, busy}, 32'd1);
        m    = DSEED;
        last = 1'b1;
        warm_wait();

        // After reset requester 0 wins the first tie
        req0 = 1'b1;
        req1 = 1'b1;
        push_exp(1'b0);
        wait_ack(30, 1'b1);
        tick();
        push_exp(1'b1);
        wait_ack(30, 1'b0);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lfsr_arbiter.md
# lfsr_arbiter

Shares one 26-bit Fibonacci LFSR between two requesters, each receiving W-bit pseudo-random words over a req/ack handshake. The block owns seeding, warm-up sequencing, round-robin arbitration and decorrelation stepping. It sits between the LFSR core and its consumers, replacing direct `load`/`din` control of the generator.

## Interface
- `W`, 8: returned word width, 1..26
- `STEPS`, 8: LFSR advances per delivered word, ≥1
- `WARMUP`, 26: LFSR advances after a seed load before first service, ≥0
- `DEFAULT_SEED`, 26'b1101_1001_0101_1010_1101_0110_01: seed applied at reset and by the zero guard
- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `seed_load`  in  1  one-cycle pulse; load `seed_din`
- `seed_din`  in  26  seed value, bit order [1:26]
- `req0`, `req1`  in  1  level request, held until matching ack
- `ack0`, `ack1`  out  1  one-cycle pulse; `rdata` valid in that cycle
- `rdata`  out  W  delivered word, held until the next delivery
- `busy`  out  1  high whenever state ≠ READY
- `lfsr_q`  out  26  current LFSR state, for observability

## Operation
- LFSR: taps 26, 6, 2, 1. Each advance: `fb = q[26]^q[6]^q[2]^q[1]`; `q[1] <= fb`; `q[i] <= q[i-1]` for i = 2..26.
- LFSR advances only in WARM and STEP. It holds in READY and DELIVER.
- States:
  - WARM: counter runs from WARMUP down; go to READY when it expires.
  - READY: idle. On any req, latch the granted index and go to STEP.
  - STEP: counter runs from STEPS down, then go to DELIVER.
  - DELIVER: pulse the granted ack, then go to READY.
- Arbitration: round-robin on a last-granted pointer. A single request is granted immediately. When both requests are high, grant the requester not served last.
- `rdata` equals `lfsr_q[1:W]` as held during DELIVER.
- A grant is latched in READY. Deasserting req after the grant does not cancel delivery.
- Requester protocol: drop req on the edge at which ack=1 is sampled. A req still high in the following READY cycle is a new request.
- `seed_load` is accepted in every state and takes priority over arbitration. On that edge:
  - LFSR ← `seed_din`;
  - any in-flight grant is abandoned without ack (the pointer is unchanged);
  - go to WARM with counter = WARMUP, or to READY if WARMUP = 0.
- `rst` and `seed_load` in the same cycle: `rst` wins.
- Reset values:
  - state WARM, counter = WARMUP (READY if WARMUP = 0);
  - `lfsr_q` = DEFAULT_SEED;
  - `ack0`, `ack1` = 0; `rdata` = 0;
  - `busy` = 1 (0 if WARMUP = 0);
  - pointer = requester 1, so req0 wins the first tie.
- `rst` mid-operation drops any grant immediately; no ack is issued.

## Timing
- Request present in a READY cycle t:
  - STEP occupies cycles t+1 .. t+STEPS;
  - ack and valid `rdata` appear in cycle t+STEPS+1;
  - READY resumes at t+STEPS+2.
- Worst-case latency with contention: 2·(STEPS+2) cycles from req to ack.
- After a seed load at edge e: WARM lasts WARMUP cycles; the first READY cycle is e+WARMUP+1.
- `busy` and all outputs are registered. No combinational path from req to ack.

## Configuration
- `LFSR_ARB_ZERO_GUARD_EN` defined: a `seed_din` of all zeros is replaced by DEFAULT_SEED at load.
- Not defined: a zero seed is loaded as-is. The LFSR locks at 0 and every `rdata` is 0. Handshake timing is unchanged.

## Structure
- Package `lfsr_pkg` holds:
  - LFSR_WIDTH = 26;
  - tap positions;
  - DEFAULT_SEED constant;
  - state enum {WARM, READY, STEP, DELIVER}.
- Sub-module `lfsr26_core` (clk, rst, load, din, step, q): shift register and feedback only. `lfsr_arbiter` holds the FSM, counters, pointer and output registers.

## Test plan
- Reset with WARMUP=26 and no requests → `busy`=1 for 26 cycles then 0; `lfsr_q` = reference model after 26 advances from DEFAULT_SEED.
- req0 asserted in READY cycle t (STEPS=8) → `ack0`=1 only in cycle t+9; `ack1` stays 0; `rdata` = model bits [1:8].
- req0 and req1 held high continuously → acks alternate 0,1,0,1 at 10-cycle spacing. Reloading the same seed reproduces an identical `rdata` sequence.
- `seed_load` with `seed_din`=0 → next cycle `lfsr_q` = DEFAULT_SEED with the macro defined, and 0 without it.
- `seed_load` during the 4th STEP cycle of a req1 grant → no ack for that grant; req1 still held is acked after 26 WARM cycles + 10 cycles.
- `rst` asserted in a DELIVER cycle (ack0 high) → next cycle `ack0`=0, `rdata`=0, `lfsr_q`=DEFAULT_SEED, `busy`=1.
